// File: rtl/mem_instr_sequencer.sv
// Instruction sequencer: fetches words from a registered ROM and issues
// read / shift handshakes, wfi stalls and counted program loops.
module mem_instr_sequencer #(
  parameter int DATA_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LANES  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   RESUME,
  input  logic [15:0]            LOOP_LIMIT,
  output logic [ADDR_WIDTH-1:0]  ROM_ADDRESS,
  output logic                   ROM_ENABLE,
  input  logic [DATA_WIDTH-1:0]  ROM_DATA,
  input  logic                   ROM_DATA_VALID,
  output logic                   RD_VALID,
  output logic [3:0]             RD_MASK,
  input  logic                   RD_READY,
  output logic                   SH_VALID,
  output logic [3:0]             SH_AMOUNT,
  output logic [3*NUM_LANES-1:0] SH_LANES,
  input  logic                   SH_READY,
  output logic                   WFI_PENDING,
  output logic                   LOOP_DONE,
  output logic                   HALTED,
  output logic                   BUSY
);

  localparam int LW = 3 * NUM_LANES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WFI,
    S_HALT
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] pc, pc_n, pc_inc;
  logic [DATA_WIDTH-1:0] ir, ir_n;
  logic [15:0]           cnt, cnt_n, cnt_inc;
  logic [3:0]            op;
  logic                  is_rd, is_sh, is_wfi, is_lp;
  logic                  rd_go, sh_go;

  assign op      = ir[7:4];
  assign is_rd   = (op == 4'b0000);
  assign is_sh   = (op == 4'b0101);
  assign is_wfi  = (op == 4'b0110);
  assign is_lp   = !(is_rd || is_sh || is_wfi);
  assign rd_go   = (ir[3:0] != 4'b0000);
  assign sh_go   = (ir[LW+7:8] != '0);
  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    cnt_n       = cnt;
    ROM_ADDRESS = '0;
    ROM_ENABLE  = 1'b0;
    RD_VALID    = 1'b0;
    RD_MASK     = '0;
    SH_VALID    = 1'b0;
    SH_AMOUNT   = '0;
    SH_LANES    = '0;
    WFI_PENDING = 1'b0;
    LOOP_DONE   = 1'b0;
    HALTED      = 1'b0;
    BUSY        = (state != S_IDLE) && (state != S_HALT);
    unique case (state)
      S_IDLE, S_HALT: begin
        HALTED = (state == S_HALT);
        if (START) begin
          pc_n    = '0;
          cnt_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        ROM_ENABLE  = 1'b1;
        ROM_ADDRESS = pc;
        state_n     = S_WAIT;
      end
      S_WAIT: begin
        if (ROM_DATA_VALID) begin
          ir_n    = ROM_DATA;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_rd: begin
            RD_VALID = rd_go;
            RD_MASK  = rd_go ? ir[3:0] : 4'b0000;
            if (!rd_go || RD_READY) begin
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end
          end
          is_sh: begin
            SH_VALID  = sh_go;
            SH_AMOUNT = sh_go ? ir[3:0] : 4'b0000;
            SH_LANES  = sh_go ? ir[LW+7:8] : '0;
            if (!sh_go || SH_READY) begin
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end
          end
          is_wfi: state_n = S_WFI;
          is_lp: begin
            LOOP_DONE = 1'b1;
            cnt_n     = cnt_inc;
            // A zero limit never matches, so the program repeats forever.
            if (LOOP_LIMIT != 16'd0 && cnt_inc == LOOP_LIMIT) begin
              state_n = S_HALT;
            end else begin
              pc_n    = '0;
              state_n = S_FETCH;
            end
          end
          default: ;
        endcase
      end
      S_WFI: begin
        WFI_PENDING = 1'b1;
        if (RESUME) begin
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
